trig_lut_scheduler: RTL and testbench
=====================================

# trig_lut_scheduler

Request-level controller for the trigonometric LUT datapath (sine, cosine and tangent LUTs). It accepts one {function, integer-degree angle} request at a time and reduces the angle modulo 360. It derives the quadrant and the 0..90 reference angle, enables exactly one LUT, and waits out the LUT latency. It then returns the captured 64-bit double over a valid/ready response port. It sits between the FPU command front-end and the three LUT instances.

## Interface
- `LUT_ANGLE_W`, 7: width of LUT angle input; holds 0..90.
- `REQ_ANGLE_W`, 16: width of request angle, in unsigned degrees.
- `LUT_LATENCY`, 1: clock edges from LUT enable/data being sampled to its output being valid; minimum 1.

- `clk`  in  1  single clock; all state on rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `req_valid`  in  1  request present.
- `req_ready`  out  1  scheduler can accept.
- `req_func`  in  2  00 sin, 01 cos, 10 tan, 11 reserved.
- `req_angle`  in  REQ_ANGLE_W  angle in degrees.
- `rsp_valid`  out  1  result present.
- `rsp_ready`  in  1  consumer accepts result.
- `rsp_data`  out  64  IEEE-754 double result.
- `rsp_err`  out  1  reserved func, or tan at 90/270.
- `lut_quadrant`  out  2  quadrant to all LUTs.
- `lut_angle`  out  LUT_ANGLE_W  reference angle to all LUTs.
- `en_sine`, `en_cosine`, `en_tangent`  out  1 each  LUT enables; one-hot or all zero.
- `sine_data`, `cosine_data`, `tangent_data`  in  64 each  LUT outputs; high-Z while disabled, never sampled then.

## Operation
States and transitions:
- IDLE
  - `req_ready` = 1.
  - On `req_valid`: latch func and angle, then go to REDUCE.
- REDUCE
  - Angle ≥ 360: subtract 360 and stay.
  - Otherwise: go to QUAD.
- QUAD
  - Register quadrant and reference angle.
  - Reserved func: set `rsp_data` = 0 and `rsp_err` = 1, skip the LUT, go to DONE.
  - Otherwise: assert the selected enable, load wait counter = LUT_LATENCY, go to WAIT.
- WAIT
  - Counter > 0: decrement.
  - Counter = 0: capture the selected LUT's data into `rsp_data`, drop the enable, go to DONE.
- DONE
  - `rsp_valid` = 1; hold `rsp_data` and `rsp_err` stable.
  - On `rsp_ready`: go to IDLE.

Quadrant and reference angle, for reduced angle a:
- 0..90: q = 0, ref = a.
- 91..180: q = 1, ref = 180 − a.
- 181..270: q = 2, ref = a − 180.
- 271..359: q = 3, ref = 360 − a.

Error rule:
- tan with ref = 90 (a = 90 or 270): `rsp_err` = 1. LUT data is still captured and returned.
- sin and cos are never flagged.

Enables, `lut_quadrant` and `lut_angle` stay constant from QUAD exit until WAIT exit. The LUT therefore never tri-states before capture.

The scheduler never applies a sign; sign is the LUT's responsibility.

## Timing
Reset values: `req_ready` 0 during reset and 1 after (IDLE); every other output 0.

Latency, counted from the accepting edge:
- `rsp_valid` rises after 3 + LUT_LATENCY + k edges, where k = floor(angle/360).
- Example: 4 edges for angle < 360 with LUT_LATENCY = 1.
- Reserved func: 2 + k edges.

Handshake:
- Accept happens on an edge with `req_valid` & `req_ready`.
- `req_ready` is low outside IDLE; there is no overlap, so one request is in flight at most.
- A response completes on an edge with `rsp_valid` & `rsp_ready`, and `req_ready` returns on that same edge.
- Holding `rsp_ready` low stalls indefinitely with outputs frozen.

Reset mid-operation: asserting `reset` in any state returns to IDLE immediately. All enables drop to 0 and any pending result is discarded.

Full reduction of 65535 takes 182 REDUCE cycles.

## Structure
Package `trig_pkg` holds:
- func encodings (FUNC_SIN/COS/TAN/RSVD);
- state enum;
- constants DEG_90/180/270/360.

LUT_ANGLE_W matches the LUT data_in width define.

Sub-module `trig_quadrant_map`: combinational mapping of a 0..359 angle to {quadrant, ref, is_90}, instantiated once in QUAD.

## Test plan
- sin 30, `rsp_ready` = 1
  - `lut_quadrant` = 0, `lut_angle` = 30.
  - `en_sine` high for 2 cycles.
  - `rsp_valid` 4 edges after accept.
  - `rsp_data` = model sine_data(30, q0), `rsp_err` = 0.
- cos 120
  - `lut_quadrant` = 1, `lut_angle` = 60.
  - Only `en_cosine` asserted.
  - `rsp_data` = cosine_data.
- tan 270
  - `lut_quadrant` = 2, `lut_angle` = 90, `rsp_err` = 1.
  - tan 90 → q0, ref 90, `rsp_err` = 1.
  - tan 89 → `rsp_err` = 0.
- sin 750
  - Two REDUCE subtractions, `lut_angle` = 30.
  - `rsp_valid` 6 edges after accept.
- func 11, angle 45
  - No enable ever asserted.
  - `rsp_valid` 2 edges after accept, `rsp_data` = 0, `rsp_err` = 1.
- Back-pressure and reset: hold `rsp_ready` = 0 for 5 cycles, then reset during WAIT of a second request.
  - During the stall, `rsp_data` is held and `req_ready` = 0.
  - The reset drops the enables asynchronously and IDLE is reached with `rsp_valid` = 0.

Source files
------------

// File: rtl/trig_pkg.sv
// Shared encodings and constants for the trigonometric LUT scheduler.
package trig_pkg;

  typedef enum logic [1:0] {
    FUNC_SIN  = 2'b00,
    FUNC_COS  = 2'b01,
    FUNC_TAN  = 2'b10,
    FUNC_RSVD = 2'b11
  } func_e;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_REDUCE = 3'd1,
    ST_QUAD   = 3'd2,
    ST_WAIT   = 3'd3,
    ST_DONE   = 3'd4
  } state_e;

  localparam logic [8:0] DEG_90  = 9'd90;
  localparam logic [8:0] DEG_180 = 9'd180;
  localparam logic [8:0] DEG_270 = 9'd270;
  localparam logic [8:0] DEG_360 = 9'd360;

endpackage

// File: rtl/trig_quadrant_map.sv
// Maps a reduced 0..359 degree angle onto its quadrant and 0..90 reference angle.
module trig_quadrant_map
  import trig_pkg::*;
#(
  parameter int LUT_ANGLE_W = 7
) (
  input  logic [8:0]             angle,
  output logic [1:0]             quadrant,
  output logic [LUT_ANGLE_W-1:0] ref_angle,
  output logic                   is_90
);

  logic [8:0] ref_full;

  always_comb begin
    quadrant = 2'd0;
    ref_full = angle;
    if (angle <= DEG_90) begin
      quadrant = 2'd0;
      ref_full = angle;
    end else if (angle <= DEG_180) begin
      quadrant = 2'd1;
      ref_full = DEG_180 - angle;
    end else if (angle <= DEG_270) begin
      quadrant = 2'd2;
      ref_full = angle - DEG_180;
    end else begin
      quadrant = 2'd3;
      ref_full = DEG_360 - angle;
    end
  end

  assign ref_angle = LUT_ANGLE_W'(ref_full);
  assign is_90     = (ref_full == DEG_90);

endmodule

// File: rtl/trig_lut_scheduler.sv
// Request-level controller: reduces the angle, drives one LUT, waits out its
// latency and returns the captured double over a valid/ready response port.
module trig_lut_scheduler
  import trig_pkg::*;
#(
  parameter int LUT_ANGLE_W = 7,
  parameter int REQ_ANGLE_W = 16,
  parameter int LUT_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [1:0]             req_func,
  input  logic [REQ_ANGLE_W-1:0] req_angle,
  output logic                   rsp_valid,
  input  logic                   rsp_ready,
  output logic [63:0]            rsp_data,
  output logic                   rsp_err,
  output logic [1:0]             lut_quadrant,
  output logic [LUT_ANGLE_W-1:0] lut_angle,
  output logic                   en_sine,
  output logic                   en_cosine,
  output logic                   en_tangent,
  input  logic [63:0]            sine_data,
  input  logic [63:0]            cosine_data,
  input  logic [63:0]            tangent_data,
  output state_e                 fsm_state
);

  localparam int CNT_W = (LUT_LATENCY < 2) ? 1 : $clog2(LUT_LATENCY + 1);
  localparam logic [REQ_ANGLE_W-1:0] FULL_TURN = REQ_ANGLE_W'(DEG_360);

  state_e                 state, state_n;
  func_e                  func_q, func_n;
  logic [REQ_ANGLE_W-1:0] angle_q, angle_n;
  logic [CNT_W-1:0]       cnt_q, cnt_n;
  logic [1:0]             quad_q, quad_n;
  logic [LUT_ANGLE_W-1:0] ref_q, ref_n;
  logic                   is90_q, is90_n;
  logic                   en_sin_q, en_sin_n;
  logic                   en_cos_q, en_cos_n;
  logic                   en_tan_q, en_tan_n;
  logic [63:0]            data_q, data_n;
  logic                   err_q, err_n;

  logic [1:0]             map_quad;
  logic [LUT_ANGLE_W-1:0] map_ref;
  logic                   map_is90;

  trig_quadrant_map #(.LUT_ANGLE_W(LUT_ANGLE_W)) u_map (
    .angle     (angle_q[8:0]),
    .quadrant  (map_quad),
    .ref_angle (map_ref),
    .is_90     (map_is90)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ST_IDLE;
      func_q   <= FUNC_SIN;
      angle_q  <= '0;
      cnt_q    <= '0;
      quad_q   <= '0;
      ref_q    <= '0;
      is90_q   <= 1'b0;
      en_sin_q <= 1'b0;
      en_cos_q <= 1'b0;
      en_tan_q <= 1'b0;
      data_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      state    <= state_n;
      func_q   <= func_n;
      angle_q  <= angle_n;
      cnt_q    <= cnt_n;
      quad_q   <= quad_n;
      ref_q    <= ref_n;
      is90_q   <= is90_n;
      en_sin_q <= en_sin_n;
      en_cos_q <= en_cos_n;
      en_tan_q <= en_tan_n;
      data_q   <= data_n;
      err_q    <= err_n;
    end
  end

  // Handshakes: a request transfers on a rising edge with req_valid & req_ready,
  // a response on a rising edge with rsp_valid & rsp_ready; neither side may
  // retract valid before the transfer, and the response is held stable meanwhile.
  always_comb begin
    state_n  = state;
    func_n   = func_q;
    angle_n  = angle_q;
    cnt_n    = cnt_q;
    quad_n   = quad_q;
    ref_n    = ref_q;
    is90_n   = is90_q;
    en_sin_n = en_sin_q;
    en_cos_n = en_cos_q;
    en_tan_n = en_tan_q;
    data_n   = data_q;
    err_n    = err_q;
    case (state)
      ST_IDLE: begin
        if (req_valid) begin
          func_n  = func_e'(req_func);
          angle_n = req_angle;
          state_n = ST_REDUCE;
        end
      end
      ST_REDUCE: begin
        if (angle_q >= FULL_TURN) angle_n = angle_q - FULL_TURN;
        else state_n = ST_QUAD;
      end
      ST_QUAD: begin
        quad_n = map_quad;
        ref_n  = map_ref;
        is90_n = map_is90;
        if (func_q == FUNC_RSVD) begin
          data_n  = '0;
          err_n   = 1'b1;
          state_n = ST_DONE;
        end else begin
          en_sin_n = (func_q == FUNC_SIN);
          en_cos_n = (func_q == FUNC_COS);
          en_tan_n = (func_q == FUNC_TAN);
          cnt_n    = CNT_W'(LUT_LATENCY);
          state_n  = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_n = cnt_q - CNT_W'(1);
        end else begin
          case (func_q)
            FUNC_SIN: data_n = sine_data;
            FUNC_COS: data_n = cosine_data;
            FUNC_TAN: data_n = tangent_data;
            default:  data_n = '0;
          endcase
          // Tangent is unbounded at a 90 degree reference; data still returned.
          err_n    = (func_q == FUNC_TAN) && is90_q;
          en_sin_n = 1'b0;
          en_cos_n = 1'b0;
          en_tan_n = 1'b0;
          state_n  = ST_DONE;
        end
      end
      ST_DONE: begin
        if (rsp_ready) state_n = ST_IDLE;
      end
      default: state_n = ST_IDLE;
    endcase
  end

  assign req_ready    = (state == ST_IDLE) && !reset;
  assign rsp_valid    = (state == ST_DONE);
  assign rsp_data     = data_q;
  assign rsp_err      = err_q;
  assign lut_quadrant = quad_q;
  assign lut_angle    = ref_q;
  assign en_sine      = en_sin_q;
  assign en_cosine    = en_cos_q;
  assign en_tangent   = en_tan_q;
  assign fsm_state    = state;

endmodule

// File: tb/tb_trig_lut_scheduler.sv
// Self-checking bench for trig_lut_scheduler with behavioural LUT models.
module tb_trig_lut_scheduler;
  import trig_pkg::*;

  localparam int LAW = 7;
  localparam int RAW = 16;
  localparam int LL  = 1;

  logic           clk = 1'b0;
  logic           reset;
  logic           req_valid;
  logic           req_ready;
  logic [1:0]     req_func;
  logic [RAW-1:0] req_angle;
  logic           rsp_valid;
  logic           rsp_ready;
  logic [63:0]    rsp_data;
  logic           rsp_err;
  logic [1:0]     lut_quadrant;
  logic [LAW-1:0] lut_angle;
  logic           en_sine, en_cosine, en_tangent;
  logic [63:0]    sine_data, cosine_data, tangent_data;
  state_e         fsm_state;

  int n_tests = 0;
  int n_fail  = 0;
  logic [64:0] exp_q[$];

  trig_lut_scheduler #(.LUT_ANGLE_W(LAW), .REQ_ANGLE_W(RAW), .LUT_LATENCY(LL)) dut (
    .clk          (clk),
    .reset        (reset),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_func     (req_func),
    .req_angle    (req_angle),
    .rsp_valid    (rsp_valid),
    .rsp_ready    (rsp_ready),
    .rsp_data     (rsp_data),
    .rsp_err      (rsp_err),
    .lut_quadrant (lut_quadrant),
    .lut_angle    (lut_angle),
    .en_sine      (en_sine),
    .en_cosine    (en_cosine),
    .en_tangent   (en_tangent),
    .sine_data    (sine_data),
    .cosine_data  (cosine_data),
    .tangent_data (tangent_data),
    .fsm_state    (fsm_state)
  );

  // clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", n_tests);
    $fatal(1, "watchdog");
  end

  // LUT models: one-edge latency, tagged data so the source is identifiable
  function automatic logic [63:0] lut_val(input logic [1:0] f, input logic [1:0] q,
                                          input logic [6:0] a);
    logic [3:0] tag;
    tag = 4'hA + {2'b00, f};
    return {tag, 28'h1234567, 16'h0, 6'h0, q, 1'b0, a};
  endfunction

  logic [63:0] sine_r, cosine_r, tangent_r;
  always @(posedge clk) begin
    sine_r    <= en_sine    ? lut_val(2'd0, lut_quadrant, lut_angle) : 64'bz;
    cosine_r  <= en_cosine  ? lut_val(2'd1, lut_quadrant, lut_angle) : 64'bz;
    tangent_r <= en_tangent ? lut_val(2'd2, lut_quadrant, lut_angle) : 64'bz;
  end
  assign sine_data    = sine_r;
  assign cosine_data  = cosine_r;
  assign tangent_data = tangent_r;

  // driver + scoreboard for one request
  task automatic run_req(input logic [1:0] f, input int angle, input int stall,
                         input string name);
    int a, q, r, k, exp_lat, edges, en_cycles;
    logic [64:0] exp;
    logic [63:0] held;
    logic [2:0]  exp_mask;
    bit got;
    a = angle % 360;
    k = angle / 360;
    q = (a == 0) ? 0 : (a - 1) / 90;
    case (q)
      0:       r = a;
      1:       r = 180 - a;
      2:       r = a - 180;
      default: r = 360 - a;
    endcase
    case (f)
      2'd0:    exp_mask = 3'b001;
      2'd1:    exp_mask = 3'b010;
      2'd2:    exp_mask = 3'b100;
      default: exp_mask = 3'b000;
    endcase
    if (f == 2'b11) begin
      exp = {1'b1, 64'h0};
      exp_lat = 2 + k;
    end else begin
      exp = {(f == 2'b10) && (r == 90), lut_val(f, 2'(q), 7'(r))};
      exp_lat = 3 + LL + k;
    end
    exp_q.push_back(exp);

    rsp_ready = (stall == 0);
    @(negedge clk);
    req_valid = 1'b1;
    req_func  = f;
    req_angle = RAW'(angle);
    n_tests++;
    if (req_ready !== 1'b1)
      $display("FAIL %s req_ready_before_accept: got %b want 1", name, req_ready);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    edges = 0;
    en_cycles = 0;
    got = 0;
    for (int i = 0; i < 400 && !got; i++) begin
      if (rsp_valid === 1'b1) begin
        got = 1;
      end else begin
        if ((en_sine | en_cosine | en_tangent) === 1'b1) begin
          en_cycles++;
          n_tests++;
          if ({en_tangent, en_cosine, en_sine} !== exp_mask ||
              lut_quadrant !== 2'(q) || lut_angle !== LAW'(r)) begin
            n_fail++;
            $display("FAIL %s lut_drive: got en=%b q=%0d ref=%0d want en=%b q=%0d ref=%0d",
                     name, {en_tangent, en_cosine, en_sine}, lut_quadrant, lut_angle,
                     exp_mask, q, r);
          end
        end
        @(posedge clk);
        #1;
        edges++;
      end
    end
    n_tests++;
    if (!got) begin
      n_fail++;
      $display("FAIL %s rsp_timeout: got no rsp_valid want valid after %0d edges",
               name, exp_lat);
    end else if (edges != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d edges want %0d", name, edges, exp_lat);
    end
    n_tests++;
    if (en_cycles != ((f == 2'b11) ? 0 : LL + 1)) begin
      n_fail++;
      $display("FAIL %s enable_cycles: got %0d want %0d", name, en_cycles,
               (f == 2'b11) ? 0 : LL + 1);
    end

    held = rsp_data;
    for (int s = 0; s < stall; s++) begin
      @(posedge clk);
      #1;
      n_tests++;
      if (rsp_valid !== 1'b1 || req_ready !== 1'b0 || rsp_data !== held) begin
        n_fail++;
        $display("FAIL %s stall_hold: got valid=%b ready=%b data=%h want 1 0 %h",
                 name, rsp_valid, req_ready, rsp_data, held);
      end
    end
    rsp_ready = 1'b1;

    exp = exp_q.pop_front();
    n_tests++;
    if ({rsp_err, rsp_data} !== exp) begin
      n_fail++;
      $display("FAIL %s response: got err=%b data=%h want err=%b data=%h",
               name, rsp_err, rsp_data, exp[64], exp[63:0]);
    end
    @(posedge clk);
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL %s release: got req_ready=%b rsp_valid=%b want 1 0",
               name, req_ready, rsp_valid);
    end
  endtask

  task automatic test_reset;
    reset = 1'b1;
    req_valid = 1'b0;
    req_func = 2'd0;
    req_angle = '0;
    rsp_ready = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b0 || rsp_valid !== 1'b0 || rsp_data !== 64'h0 ||
        rsp_err !== 1'b0 || lut_quadrant !== 2'd0 || lut_angle !== '0 ||
        {en_sine, en_cosine, en_tangent} !== 3'b000) begin
      n_fail++;
      $display("FAIL reset_values: got rdy=%b vld=%b data=%h err=%b q=%0d ref=%0d en=%b want all 0",
               req_ready, rsp_valid, rsp_data, rsp_err, lut_quadrant, lut_angle,
               {en_sine, en_cosine, en_tangent});
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || fsm_state !== ST_IDLE) begin
      n_fail++;
      $display("FAIL reset_release: got req_ready=%b state=%0d want 1 %0d",
               req_ready, fsm_state, ST_IDLE);
    end
  endtask

  task automatic test_basic;
    run_req(2'd0, 30, 0, "sin30");
    run_req(2'd1, 120, 0, "cos120");
    run_req(2'd2, 270, 0, "tan270");
    run_req(2'd2, 90, 0, "tan90");
    run_req(2'd2, 89, 0, "tan89");
    run_req(2'd0, 750, 0, "sin750");
    run_req(2'd3, 45, 0, "rsvd45");
  endtask

  task automatic test_boundaries;
    run_req(2'd0, 0, 0, "sin0");
    run_req(2'd1, 180, 0, "cos180");
    run_req(2'd2, 181, 0, "tan181");
    run_req(2'd0, 271, 0, "sin271");
    run_req(2'd1, 359, 0, "cos359");
    run_req(2'd0, 360, 0, "sin360");
    run_req(2'd1, 65535, 0, "cos65535");
    run_req(2'd3, 1000, 0, "rsvd1000");
  endtask

  task automatic test_stall_and_reset;
    bit reached;
    run_req(2'd1, 200, 5, "cos200_stall");
    rsp_ready = 1'b1;
    @(negedge clk);
    req_valid = 1'b1;
    req_func  = 2'd2;
    req_angle = RAW'(45);
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    reached = 0;
    for (int i = 0; i < 20 && !reached; i++) begin
      if (fsm_state === ST_WAIT) reached = 1;
      else begin
        @(posedge clk);
        #1;
      end
    end
    n_tests++;
    if (!reached) begin
      n_fail++;
      $display("FAIL mid_reset_wait: got state=%0d want %0d", fsm_state, ST_WAIT);
    end
    #2;
    reset = 1'b1;
    #1;
    n_tests++;
    if ({en_sine, en_cosine, en_tangent} !== 3'b000 || rsp_valid !== 1'b0 ||
        fsm_state !== ST_IDLE || req_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset: got en=%b vld=%b state=%0d rdy=%b want 000 0 %0d 0",
               {en_sine, en_cosine, en_tangent}, rsp_valid, fsm_state, req_ready, ST_IDLE);
    end
    @(negedge clk);
    reset = 1'b0;
    #1;
    n_tests++;
    if (req_ready !== 1'b1 || rsp_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_release: got rdy=%b vld=%b want 1 0", req_ready, rsp_valid);
    end
    run_req(2'd0, 150, 0, "sin150_after_reset");
  endtask

  task automatic test_random;
    for (int i = 0; i < 8; i++)
      run_req(2'($urandom_range(0, 3)), int'($urandom_range(0, 1500)),
              int'($urandom_range(0, 2)), "random");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_boundaries();
    test_stall_and_reset();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
